// File: rtl/pingpong_run_controller.sv
// pingpong_run_controller: run-control sequencer for the ping-pong counter datapath
//   clk, rst            board clock, synchronous active-high reset
//   start               pulse: latch max_sw/min_sw, clear datapath, run (or error)
//   pause_tgl           pulse: toggle RUN/PAUSE
//   flip_btn            pulse: request a direction flip while running
//   max_sw, min_sw      requested bounds; cnt_value is the live datapath count
//   cfg_max, cfg_min    bounds latched at start
//   cnt_clear           one cycle in LOAD
//   step, flip_req      single-cycle datapath controls
//   running/done/err    state flags; state is IDLE=0 LOAD=1 RUN=2 PAUSE=3 DONE=4 ERROR=5
//   lap_cnt             top-bound reversals since the last start, saturating at 255
//   Optional macro BOUNCE_LIMIT_EN: stop in DONE once lap_cnt reaches MAX_LAPS.
module pingpong_run_controller #(
   parameter int WIDTH    = 4,
   parameter int TICK_DIV = 33554432,
   parameter int MAX_LAPS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             pause_tgl,
   input  logic             flip_btn,
   input  logic [WIDTH-1:0] max_sw,
   input  logic [WIDTH-1:0] min_sw,
   input  logic [WIDTH-1:0] cnt_value,
   output logic [WIDTH-1:0] cfg_max,
   output logic [WIDTH-1:0] cfg_min,
   output logic             cnt_clear,
   output logic             step,
   output logic             flip_req,
   output logic             running,
   output logic             done,
   output logic             err,
   output logic [7:0]       lap_cnt,
   output logic [2:0]       state
);
   typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, PAUSE = 3'd3, DONE = 3'd4, ERROR = 3'd5} state_t;
   localparam int PW = $clog2(TICK_DIV);
`ifdef BOUNCE_LIMIT_EN
   localparam bit BOUNCE = 1'b1;
`else
   localparam bit BOUNCE = 1'b0;
`endif
   state_t          st, nxt;
   logic [PW-1:0]   psc;
   logic            tick_pend;
   logic            go, tick, lap_hit;
   logic [7:0]      lap_nxt;
   // go: still in RUN after start/pause arbitration; a tick loses only to flip and is then held one cycle
   assign go       = st == RUN && !start && !pause_tgl;
   assign tick     = psc == PW'(TICK_DIV - 1) || tick_pend;
   assign step     = go && !flip_btn && tick;
   assign flip_req = go && flip_btn;
   assign lap_hit  = step && cnt_value == cfg_max;
   assign lap_nxt  = (lap_hit && lap_cnt != 8'hff) ? lap_cnt + 8'd1 : lap_cnt;
   assign state    = st;
   always_comb begin
      nxt = st;
      case (st)
         IDLE, DONE, ERROR: nxt = start ? LOAD : st;
         LOAD:              nxt = cfg_max > cfg_min ? RUN : ERROR;
         RUN: begin
            if (start) nxt = LOAD;
            else if (pause_tgl) nxt = PAUSE;
            else if (BOUNCE && lap_hit && 32'(lap_nxt) == MAX_LAPS) nxt = DONE;
         end
         PAUSE:             nxt = start ? LOAD : pause_tgl ? RUN : PAUSE;
         default:           nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= IDLE;
         running   <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         cnt_clear <= 1'b0;
         cfg_max   <= '0;
         cfg_min   <= '0;
         psc       <= '0;
         tick_pend <= 1'b0;
         lap_cnt   <= '0;
      end else begin
         st        <= nxt;
         running   <= nxt == RUN;
         done      <= nxt == DONE;
         err       <= nxt == ERROR;
         cnt_clear <= nxt == LOAD;
         tick_pend <= go && flip_btn && tick;
         if (nxt == LOAD) begin
            cfg_max <= max_sw;
            cfg_min <= min_sw;
            psc     <= '0;
            lap_cnt <= '0;
         end else begin
            lap_cnt <= lap_nxt;
            if (go) psc <= psc == PW'(TICK_DIV - 1) ? '0 : psc + PW'(1);
         end
      end
   end
endmodule

// File: tb/tb_pingpong_run_controller.sv
// tb_pingpong_run_controller: directed bench with a cycle-level behavioural model of the run controller
module tb_pingpong_run_controller;
   localparam int TD = 4;
   localparam int ML = 3;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, pause_tgl = 1'b0, flip_btn = 1'b0;
   logic [3:0] max_sw = '0, min_sw = '0, cnt_value = '0;
   logic [3:0] cfg_max, cfg_min;
   logic       cnt_clear, step, flip_req, running, done, err;
   logic [7:0] lap_cnt;
   logic [2:0] state;
   pingpong_run_controller #(.WIDTH(4), .TICK_DIV(TD), .MAX_LAPS(ML)) dut (
      .clk(clk), .rst(rst), .start(start), .pause_tgl(pause_tgl), .flip_btn(flip_btn),
      .max_sw(max_sw), .min_sw(min_sw), .cnt_value(cnt_value),
      .cfg_max(cfg_max), .cfg_min(cfg_min), .cnt_clear(cnt_clear), .step(step),
      .flip_req(flip_req), .running(running), .done(done), .err(err),
      .lap_cnt(lap_cnt), .state(state)
   );
   always #5 clk = ~clk;
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int steps[$];
   int flips[$];
   // model: phase counts progressed RUN cycles modulo TD; owed marks a step pushed back by a flip
   int         m_st = 0, m_phase = 0, m_lap = 0;
   bit         m_owed = 0;
   logic [3:0] m_max = '0, m_min = '0;
   function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", n, cyc, a, e);
      end
   endfunction
   task automatic step_cyc();
      bit live, due, e_step, e_flip, lap_now;
      #1;
      live   = m_st == 2 && !start && !pause_tgl;
      due    = (m_phase + 1) % TD == 0 || m_owed;
      e_step = live && !flip_btn && due;
      e_flip = live && flip_btn;
      chk("state", 32'(state), 32'(m_st));
      chk("running", 32'(running), 32'(m_st == 2));
      chk("done", 32'(done), 32'(m_st == 4));
      chk("err", 32'(err), 32'(m_st == 5));
      chk("cnt_clear", 32'(cnt_clear), 32'(m_st == 1));
      chk("cfg_max", 32'(cfg_max), 32'(m_max));
      chk("cfg_min", 32'(cfg_min), 32'(m_min));
      chk("lap_cnt", 32'(lap_cnt), 32'(m_lap));
      chk("step", 32'(step), 32'(e_step));
      chk("flip_req", 32'(flip_req), 32'(e_flip));
      if (step === 1'b1) steps.push_back(cyc);
      if (flip_req === 1'b1) flips.push_back(cyc);
      lap_now = 0;
      if (rst) begin
         m_st = 0; m_phase = 0; m_lap = 0; m_owed = 0; m_max = '0; m_min = '0;
      end else if (start && m_st != 1) begin
         m_st = 1; m_phase = 0; m_lap = 0; m_owed = 0; m_max = max_sw; m_min = min_sw;
      end else if (m_st == 1) begin
         m_st = m_max > m_min ? 2 : 5;
      end else if (m_st == 2) begin
         if (pause_tgl) begin
            m_st = 3; m_owed = 0;
         end else begin
            if (e_step && cnt_value == m_max && m_lap < 255) begin
               m_lap++;
               lap_now = 1;
            end
`ifdef BOUNCE_LIMIT_EN
            if (lap_now && m_lap == ML) m_st = 4;
`endif
            m_phase = (m_phase + 1) % TD;
            m_owed  = flip_btn && due;
         end
      end else if (m_st == 3 && pause_tgl) begin
         m_st = 2;
      end
      @(negedge clk);
      cyc++;
      start = 0; pause_tgl = 0; flip_btn = 0; rst = 0;
   endtask
   task automatic run(int n);
      for (int i = 0; i < n; i++) step_cyc();
   endtask
   initial begin
      int r, f;
      @(posedge clk);
      @(negedge clk);
      rst = 1;
      step_cyc();
      chk("reset_state_lit", 32'(state), 0);
      // bounds 5/2: LOAD in cycle 1, steps at 5, 9, 13
      cyc = 0;
      steps.delete();
      max_sw = 4'd5; min_sw = 4'd2; start = 1;
      step_cyc();
      #1;
      chk("load_clear_lit", 32'(cnt_clear), 1);
      chk("load_cfgmax_lit", 32'(cfg_max), 5);
      chk("load_cfgmin_lit", 32'(cfg_min), 2);
      run(14);
      chk("step_count_lit", steps.size(), 3);
      chk("step0_lit", steps[0], 5);
      chk("step1_lit", steps[1], 9);
      chk("step2_lit", steps[2], 13);
      // three steps at the top bound
      cnt_value = 4'd5;
      run(12);
      #1;
      chk("laps_lit", 32'(lap_cnt), 3);
`ifdef BOUNCE_LIMIT_EN
      chk("done_state_lit", 32'(state), 4);
      chk("done_flag_lit", 32'(done), 1);
      steps.delete();
      run(10);
      chk("done_no_step_lit", steps.size(), 0);
`else
      chk("still_run_lit", 32'(state), 2);
`endif
      // pause at prescaler 2, flips ignored while paused, resume
      cnt_value = 4'd0;
      start = 1;
      step_cyc();
      for (int i = 0; i < 20 && !(m_st == 2 && m_phase == 2); i++) step_cyc();
      chk("wait_phase2", 32'(m_st == 2 && m_phase == 2), 1);
      pause_tgl = 1;
      step_cyc();
      flips.delete();
      for (int i = 0; i < 10; i++) begin
         flip_btn = i[0];
         step_cyc();
      end
      chk("pause_no_flip_lit", flips.size(), 0);
      steps.delete();
      r = cyc;
      pause_tgl = 1;
      step_cyc();
      run(6);
      chk("resume_step_lit", steps[0], r + 2);
      chk("resume_step2_lit", steps[1], r + 6);
      // flip on the terminal count
      for (int i = 0; i < 20 && !(m_st == 2 && m_phase == TD - 1); i++) step_cyc();
      chk("wait_term", 32'(m_st == 2 && m_phase == TD - 1), 1);
      steps.delete();
      flips.delete();
      f = cyc;
      flip_btn = 1;
      step_cyc();
      run(6);
      chk("flip_same_cycle_lit", flips[0], f);
      chk("flip_step_defer_lit", steps[0], f + 1);
      chk("flip_cadence_lit", steps[1], f + 4);
      // start beats pause
      start = 1; pause_tgl = 1;
      step_cyc();
      #1;
      chk("start_pause_load_lit", 32'(state), 1);
      step_cyc();
      #1;
      chk("start_pause_run_lit", 32'(state), 2);
      // rejected bounds
      max_sw = 4'd3; min_sw = 4'd3; start = 1;
      run(2);
      #1;
      chk("err_equal_state_lit", 32'(state), 5);
      chk("err_equal_flag_lit", 32'(err), 1);
      steps.delete();
      run(20);
      chk("err_equal_no_step_lit", steps.size(), 0);
      max_sw = 4'd2; min_sw = 4'd7; start = 1;
      run(2);
      #1;
      chk("err_inverted_state_lit", 32'(state), 5);
      chk("err_keeps_cfg_lit", 32'(cfg_min), 7);
      run(20);
      chk("err_inverted_no_step_lit", steps.size(), 0);
      max_sw = 4'd7; min_sw = 4'd2; start = 1;
      run(2);
      #1;
      chk("recover_run_lit", 32'(state), 2);
      // reset mid-RUN after two laps
      max_sw = 4'd5; min_sw = 4'd2; cnt_value = 4'd5; start = 1;
      step_cyc();
      for (int i = 0; i < 40 && m_lap != 2; i++) step_cyc();
      chk("wait_two_laps", 32'(lap_cnt), 2);
      rst = 1;
      step_cyc();
      #1;
      chk("rst_state_lit", 32'(state), 0);
      chk("rst_lap_lit", 32'(lap_cnt), 0);
      chk("rst_cfg_lit", 32'(cfg_max), 0);
      steps.delete();
      run(12);
      chk("rst_no_step_lit", steps.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
